btb_update_queue: RTL and testbench
===================================

// Module: btb_update_queue
// PURPOSE
// - Producer side of the BTB update port (update_en/pc_u/target_u/taken_u/type_u). Sits at commit,
//   between retired control-flow instructions and the fetch-stage BTB.
// - Filters out resolved branches that need no update and queues the rest. Merges repeat updates
//   to the same PC, then drains one update per cycle into the BTB.
// - Updates are hints: commit is never stalled. Overflow drops the update and counts it.
// PARAMETERS
// - DEPTH  4   queue entries (power of 2, >=2)
// - CNT_W  16  width of the saturating perf counters
// PORTS
// - clk                clk   1        single clock, all state on posedge
// - reset_n            in    1        asynchronous, active-low reset
// - res_valid_i        in    1        committed control-flow instr this cycle
// - res_pc_i           in    64       PC of branch
// - res_target_i       in    64       resolved target (bits [1:0] ignored)
// - res_taken_i        in    1        resolved direction
// - res_type_i         in    btb_type_t  resolved branch type (2b)
// - res_pred_hit_i     in    1        BTB hit recorded at fetch for this instr
// - res_pred_target_i  in    64       target predicted at fetch
// - res_pred_type_i    in    btb_type_t  type predicted at fetch
// - drain_en_i         in    1        0 = hold queue (e.g. BTB busy/fetch redirect)
// - update_en_o        out   1        BTB write strobe
// - pc_u_o             out   64       BTB update PC
// - target_u_o         out   64       BTB update target
// - taken_u_o          out   1        always 1 when update_en_o=1, else 0
// - type_u_o           out   btb_type_t  BTB update type
// - q_count_o          out   $clog2(DEPTH)+1  occupied entries
// - drop_cnt_o         out   CNT_W    updates dropped on full, saturating
// - merge_cnt_o        out   CNT_W    updates merged into an existing entry, saturating
// BEHAVIOUR
// - Interface: one clock; reset is asynchronous and active-low (clk, reset_n).
// - Reset: queue empty, rd/wr ptrs 0, all entry valids 0, counters 0.
//   update_en_o=0, taken_u_o=0, pc_u_o/target_u_o/type_u_o=0, q_count_o=0.
// - need = res_valid_i & res_taken_i & (~res_pred_hit_i | res_pred_target_i[63:2]!=res_target_i[63:2]
//   | res_pred_type_i!=res_type_i). Not-taken or correctly predicted branches are never queued.
// - Entry = {valid, pc[63:0], target[63:2], type}. Circular FIFO, ptr wraps modulo DEPTH.
// - Drain: deq = ~empty & drain_en_i.
//   - update_en_o = deq (combinational).
//   - pc_u_o/target_u_o/type_u_o come from the head entry registers; target_u_o = {target[63:2],2'b00}.
//   - When update_en_o=0, the data outputs are 0.
//   - Head pops on the same edge.
// - Merge: if need and a valid non-draining entry has pc==res_pc_i, overwrite that entry's
//   target/type in place. No push. merge_cnt_o++.
//   - At most one entry can match, because merging keeps pcs unique.
//   - The head entry, while deq=1, is excluded from matching.
// - Push: need & ~merge & (~full | deq) -> write at wr_ptr, wr_ptr++.
// - Drop: need & ~merge & full & ~deq -> discard, drop_cnt_o++.
// - Push and deq in the same cycle: count unchanged. Push while full with deq=1 is accepted.
// - Latency: a push at edge N is visible at the head no earlier than cycle N+1.
//   Empty queue + drain_en_i=1 -> update_en_o high in the cycle after res_valid_i.
//   There is no combinational bypass from res_* to update outputs.
// - Counters saturate at all-ones and never wrap.
// - reset_n asserted mid-operation: queued updates are lost and outputs go to their reset values
//   immediately (async). Losing these updates is acceptable: BTB content is only a hint.
// TESTING
// - Reset/idle check.
//   - Stimulus: reset_n low mid-traffic.
//   - Required: update_en_o=0 and q_count_o=0 immediately. After release with res_valid_i=0,
//     update_en_o stays 0 for 20 cycles.
// - Filter check.
//   - Stimulus: taken, pred_hit=1, pred_target==target=0x8000_1000, same type.
//   - Required: no push.
//   - Stimulus: same branch but pred_target=0x8000_2000.
//   - Required: next cycle update_en_o=1, pc_u_o=res_pc, target_u_o=0x8000_1000, taken_u_o=1.
// - Not-taken check.
//   - Stimulus: res_taken_i=0, pred_hit=0.
//   - Required: never queued; q_count_o stays 0.
// - Merge check.
//   - Stimulus: drain_en_i=0; push pc=0x100 target=0x200; then pc=0x100 target=0x300.
//   - Required: q_count_o=1, merge_cnt_o=1. After drain_en_i=1, exactly one update with
//     target_u_o=0x300.
// - Overflow and full+drain check.
//   - Stimulus: drain_en_i=0; send DEPTH+2 distinct pcs.
//   - Required: q_count_o=DEPTH, drop_cnt_o=2.
//   - Stimulus: then one new pc in the same cycle as drain_en_i=1.
//   - Required: accepted, q_count_o stays DEPTH, drop_cnt_o stays 2. Drain order matches
//     push order.
// - Head-drain exclusion check.
//   - Stimulus: single entry pc=0x40; assert drain_en_i and a new need for pc=0x40 in the
//     same cycle.
//   - Required: head drains with the old target. The new one is pushed, not merged
//     (q_count_o=1), and drains next cycle with the new target.

Source files
------------

// File: rtl/btb_update_queue.sv
// Commit-side BTB update queue: filters retired branches that need a BTB write, merges
// repeats to the same PC, and drains one update per cycle. Updates are hints; overflow drops.
package btb_update_queue_pkg;
  typedef logic [1:0] btb_type_t;
endpackage

module btb_update_queue
  import btb_update_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       res_valid_i,
  input  logic [63:0]                res_pc_i,
  input  logic [63:0]                res_target_i,
  input  logic                       res_taken_i,
  input  btb_type_t                  res_type_i,
  input  logic                       res_pred_hit_i,
  input  logic [63:0]                res_pred_target_i,
  input  btb_type_t                  res_pred_type_i,
  input  logic                       drain_en_i,
  output logic                       update_en_o,
  output logic [63:0]                pc_u_o,
  output logic [63:0]                target_u_o,
  output logic                       taken_u_o,
  output btb_type_t                  type_u_o,
  output logic [$clog2(DEPTH):0]     q_count_o,
  output logic [CNT_W-1:0]           drop_cnt_o,
  output logic [CNT_W-1:0]           merge_cnt_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [63:0]      pc_q  [DEPTH];
  logic [63:0]      pc_d  [DEPTH];
  logic [61:0]      tgt_q [DEPTH];
  logic [61:0]      tgt_d [DEPTH];
  btb_type_t        typ_q [DEPTH];
  btb_type_t        typ_d [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [CNT_W-1:0] drop_q, drop_d, merge_q, merge_d;

  logic             need_s, deq_s, empty_s, full_s;
  logic             merge_s, push_s, drop_s;
  logic [DEPTH-1:0] match_s;
  logic [AW-1:0]    merge_idx_s;
  logic             unused_s;

  // A write is only worth queuing when the fetch-time prediction was wrong for a taken branch.
  function automatic logic need_update(input logic valid, input logic taken, input logic hit,
                                       input logic [61:0] pred_tgt, input logic [61:0] tgt,
                                       input btb_type_t pred_typ, input btb_type_t typ);
    need_update = valid & taken & (~hit | (pred_tgt != tgt) | (pred_typ != typ));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic en);
    if (en && (cnt != {CNT_W{1'b1}})) begin
      sat_inc = cnt + CNT_W'(1);
    end else begin
      sat_inc = cnt;
    end
  endfunction

  assign unused_s = ^{res_target_i[1:0], res_pred_target_i[1:0]};

  // Queue status and the merge/push/drop decision for this cycle.
  always_comb begin
    need_s = need_update(res_valid_i, res_taken_i, res_pred_hit_i, res_pred_target_i[63:2],
                         res_target_i[63:2], res_pred_type_i, res_type_i);
    empty_s     = (count_q == {(AW+1){1'b0}});
    full_s      = (count_q == (AW+1)'(DEPTH));
    deq_s       = ~empty_s & drain_en_i;
    match_s     = {DEPTH{1'b0}};
    merge_idx_s = {AW{1'b0}};
    // The head being written to the BTB this cycle must not absorb a newer update.
    for (int i = 0; i < DEPTH; i++) begin
      match_s[i]  = vld_q[i] & (pc_q[i] == res_pc_i) & ~(deq_s & (rd_ptr_q == AW'(i)));
      merge_idx_s = merge_idx_s | (match_s[i] ? AW'(i) : {AW{1'b0}});
    end
    merge_s = need_s & (|match_s);
    push_s  = need_s & ~merge_s & (~full_s | deq_s);
    drop_s  = need_s & ~merge_s & full_s & ~deq_s;
  end

  // Next-state for entries, pointers and counters.
  always_comb begin
    vld_d    = vld_q;
    pc_d     = pc_q;
    tgt_d    = tgt_q;
    typ_d    = typ_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (deq_s) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (merge_s) begin
      tgt_d[merge_idx_s] = res_target_i[63:2];
      typ_d[merge_idx_s] = res_type_i;
    end else begin
      merge_idx_s_unused_hold();
    end
    // On full+deq the write slot equals the popping head, so the push overrides the clear above.
    if (push_s) begin
      vld_d[wr_ptr_q] = 1'b1;
      pc_d[wr_ptr_q]  = res_pc_i;
      tgt_d[wr_ptr_q] = res_target_i[63:2];
      typ_d[wr_ptr_q] = res_type_i;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    count_d = count_q + (AW+1)'(push_s) - (AW+1)'(deq_s);
    drop_d  = sat_inc(drop_q, drop_s);
    merge_d = sat_inc(merge_q, merge_s);
  end

  function automatic void merge_idx_s_unused_hold();
  endfunction

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q    <= {DEPTH{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      wr_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
      drop_q   <= {CNT_W{1'b0}};
      merge_q  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]  <= 64'd0;
        tgt_q[i] <= 62'd0;
        typ_q[i] <= 2'd0;
      end
    end else begin
      vld_q    <= vld_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
      merge_q  <= merge_d;
      pc_q     <= pc_d;
      tgt_q    <= tgt_d;
      typ_q    <= typ_d;
    end
  end

  // BTB write port: head entry gated by the dequeue strobe, zero otherwise.
  always_comb begin
    update_en_o = deq_s;
    taken_u_o   = deq_s;
    if (deq_s) begin
      pc_u_o     = pc_q[rd_ptr_q];
      target_u_o = {tgt_q[rd_ptr_q], 2'b00};
      type_u_o   = typ_q[rd_ptr_q];
    end else begin
      pc_u_o     = 64'd0;
      target_u_o = 64'd0;
      type_u_o   = 2'd0;
    end
    q_count_o   = count_q;
    drop_cnt_o  = drop_q;
    merge_cnt_o = merge_q;
  end

endmodule

// File: tb/tb_btb_update_queue.sv
// Randomized plus directed bench for btb_update_queue against a queue-based reference model.
module tb_btb_update_queue;
  import btb_update_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        res_valid, res_taken, res_pred_hit, drain_en;
  logic [63:0] res_pc, res_target, res_pred_target;
  btb_type_t   res_type, res_pred_type;
  logic        update_en_o, taken_u_o;
  logic [63:0] pc_u_o, target_u_o;
  btb_type_t   type_u_o;
  logic [2:0]  q_count_o;
  logic [CNT_W-1:0] drop_cnt_o, merge_cnt_o;

  btb_update_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .res_valid_i(res_valid), .res_pc_i(res_pc), .res_target_i(res_target),
    .res_taken_i(res_taken), .res_type_i(res_type), .res_pred_hit_i(res_pred_hit),
    .res_pred_target_i(res_pred_target), .res_pred_type_i(res_pred_type),
    .drain_en_i(drain_en), .update_en_o(update_en_o), .pc_u_o(pc_u_o),
    .target_u_o(target_u_o), .taken_u_o(taken_u_o), .type_u_o(type_u_o),
    .q_count_o(q_count_o), .drop_cnt_o(drop_cnt_o), .merge_cnt_o(merge_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] tgt;
    logic [1:0]  typ;
  } ent_t;

  ent_t        mq[$];
  int          m_drop, m_merge;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] pool[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_drop  = 0;
    m_merge = 0;
  endtask

  // Reference: list of pending updates; oldest at index 0.
  task automatic model_step();
    bit need, deq;
    int found;
    int sz;
    if (!reset_n) return;
    need = res_valid && res_taken &&
           (!res_pred_hit || (res_pred_target >> 2) != (res_target >> 2) || res_pred_type != res_type);
    sz  = mq.size();
    deq = (sz > 0) && drain_en;
    found = -1;
    for (int i = 0; i < sz; i++) begin
      if (!(deq && i == 0) && mq[i].pc == res_pc) found = i;
    end
    if (need && found >= 0) begin
      mq[found].tgt = {res_target[63:2], 2'b00};
      mq[found].typ = res_type;
      if (m_merge < (1 << CNT_W) - 1) m_merge++;
    end
    if (deq) void'(mq.pop_front());
    if (need && found < 0) begin
      if (sz < DEPTH || deq) begin
        mq.push_back('{pc: res_pc, tgt: {res_target[63:2], 2'b00}, typ: res_type});
      end else if (m_drop < (1 << CNT_W) - 1) begin
        m_drop++;
      end
    end
  endtask

  task automatic compare();
    bit exp_deq;
    exp_deq = (mq.size() > 0) && drain_en;
    chk("update_en", {63'd0, update_en_o}, {63'd0, exp_deq});
    chk("taken_u", {63'd0, taken_u_o}, {63'd0, exp_deq});
    if (exp_deq) begin
      chk("pc_u", pc_u_o, mq[0].pc);
      chk("target_u", target_u_o, mq[0].tgt);
      chk("type_u", {62'd0, type_u_o}, {62'd0, mq[0].typ});
    end else begin
      chk("pc_u_idle", pc_u_o, 64'd0);
      chk("target_u_idle", target_u_o, 64'd0);
      chk("type_u_idle", {62'd0, type_u_o}, 64'd0);
    end
    chk("q_count", {61'd0, q_count_o}, 64'(mq.size()));
    chk("drop_cnt", {48'd0, drop_cnt_o}, 64'(m_drop));
    chk("merge_cnt", {48'd0, merge_cnt_o}, 64'(m_merge));
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] pc, input logic [63:0] tgt, input logic [1:0] typ,
                      input logic drain);
    res_valid = 1'b1; res_taken = 1'b1; res_pred_hit = 1'b0;
    res_pc = pc; res_target = tgt; res_type = typ;
    res_pred_target = 64'd0; res_pred_type = typ;
    drain_en = drain;
    tick();
    res_valid = 1'b0;
  endtask

  task automatic idle_check(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      chk("idle_update_en", {63'd0, update_en_o}, 64'd0);
    end
  endtask

  task automatic rand_cycle(input int drain_pct);
    res_valid       = ($urandom_range(99) < 70);
    res_taken       = ($urandom_range(99) < 75);
    res_pred_hit    = $urandom_range(1);
    res_pc          = pool[$urandom_range(5)];
    res_target      = {$urandom(), $urandom()};
    res_type        = 2'($urandom_range(3));
    res_pred_target = $urandom_range(1) ? res_target : {$urandom(), $urandom()};
    res_pred_type   = $urandom_range(1) ? res_type : 2'($urandom_range(3));
    drain_en        = ($urandom_range(99) < drain_pct);
    tick();
  endtask

  initial begin
    logic [63:0] order[4];
    for (int i = 0; i < 6; i++) pool[i] = {$urandom(), $urandom()};
    reset_n = 1'b0;
    res_valid = 1'b0; res_taken = 1'b0; res_pred_hit = 1'b0; drain_en = 1'b0;
    res_pc = 64'd0; res_target = 64'd0; res_pred_target = 64'd0;
    res_type = 2'd0; res_pred_type = 2'd0;
    model_reset();
    #1;
    chk("reset_update_en", {63'd0, update_en_o}, 64'd0);
    chk("reset_q_count", {61'd0, q_count_o}, 64'd0);
    repeat (3) tick();
    reset_n = 1'b1;
    drain_en = 1'b1;
    idle_check(20);

    // Filter: correctly predicted, then mispredicted target.
    res_valid = 1'b1; res_taken = 1'b1; res_pred_hit = 1'b1;
    res_pc = 64'h1234; res_target = 64'h8000_1000; res_pred_target = 64'h8000_1000;
    res_type = 2'd2; res_pred_type = 2'd2;
    tick();
    res_valid = 1'b0;
    chk("filter_hit_q_count", {61'd0, q_count_o}, 64'd0);
    chk("filter_hit_update_en", {63'd0, update_en_o}, 64'd0);
    res_valid = 1'b1; res_pred_target = 64'h8000_2000;
    tick();
    res_valid = 1'b0;
    chk("filter_miss_update_en", {63'd0, update_en_o}, 64'd1);
    chk("filter_miss_pc", pc_u_o, 64'h1234);
    chk("filter_miss_target", target_u_o, 64'h8000_1000);
    chk("filter_miss_taken", {63'd0, taken_u_o}, 64'd1);

    // Not-taken branches never queue.
    res_valid = 1'b1; res_taken = 1'b0; res_pred_hit = 1'b0; res_pc = 64'h5555; res_target = 64'h9000;
    tick();
    tick();
    res_valid = 1'b0;
    chk("not_taken_q_count", {61'd0, q_count_o}, 64'd0);

    // Merge of a repeat pc while the queue is held.
    send(64'h100, 64'h200, 2'd1, 1'b0);
    send(64'h100, 64'h300, 2'd1, 1'b0);
    chk("merge_q_count", {61'd0, q_count_o}, 64'd1);
    chk("merge_cnt", {48'd0, merge_cnt_o}, 64'd1);
    drain_en = 1'b1;
    #1;
    chk("merge_drain_target", target_u_o, 64'h300);
    tick();
    chk("merge_drain_once", {63'd0, update_en_o}, 64'd0);

    // Overflow, then push while full with drain.
    for (int i = 0; i < DEPTH + 2; i++) send(64'h1000 + 64'(16 * i), 64'h7000 + 64'(16 * i), 2'd0, 1'b0);
    chk("ovf_q_count", {61'd0, q_count_o}, 64'd4);
    chk("ovf_drop_cnt", {48'd0, drop_cnt_o}, 64'd2);
    drain_en = 1'b1;
    #1;
    chk("ovf_first_pc", pc_u_o, 64'h1000);
    send(64'h2000, 64'h7100, 2'd3, 1'b1);
    chk("full_push_q_count", {61'd0, q_count_o}, 64'd4);
    chk("full_push_drop_cnt", {48'd0, drop_cnt_o}, 64'd2);
    order[0] = 64'h1010; order[1] = 64'h1020; order[2] = 64'h1030; order[3] = 64'h2000;
    for (int i = 0; i < 4; i++) begin
      chk("drain_order_pc", pc_u_o, order[i]);
      tick();
    end
    chk("drain_order_empty", {61'd0, q_count_o}, 64'd0);

    // Head being drained is not a merge target.
    send(64'h40, 64'h80, 2'd2, 1'b0);
    drain_en = 1'b1;
    #1;
    chk("excl_old_target", target_u_o, 64'h80);
    send(64'h40, 64'hC0, 2'd2, 1'b1);
    chk("excl_q_count", {61'd0, q_count_o}, 64'd1);
    chk("excl_merge_cnt", {48'd0, merge_cnt_o}, 64'd1);
    chk("excl_new_target", target_u_o, 64'hC0);
    tick();

    for (int i = 0; i < 1500; i++) rand_cycle(30);
    for (int i = 0; i < 1500; i++) rand_cycle(70);

    // Asynchronous reset in the middle of traffic.
    res_valid = 1'b0;
    send(64'hA00, 64'hB00, 2'd1, 1'b0);
    send(64'hA10, 64'hB10, 2'd1, 1'b0);
    drain_en = 1'b1;
    #1;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("midreset_update_en", {63'd0, update_en_o}, 64'd0);
    chk("midreset_q_count", {61'd0, q_count_o}, 64'd0);
    tick();
    tick();
    reset_n = 1'b1;
    idle_check(20);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
